// File: rtl/pot_scan_if.sv
// A2D_intf handshake bundle: the scanner (master) requests conversions and the
// converter (slave) answers with a completion pulse and the result.
interface pot_scan_if #(
  parameter int RES_W = 12
);
  logic             strt_cnv;
  logic [2:0]       chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/pot_scan.sv
// Round-robin slide-pot scanner: walks a channel list through the A2D handshake,
// IIR-smooths each slot and reports it through a deadband with a change strobe.
module pot_scan #(
  parameter int                    NUM_CH      = 6,
  parameter int                    RES_W       = 12,
  parameter logic [3*NUM_CH-1:0]   CHNL_MAP    = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int                    ALPHA_SH    = 2,
  parameter int                    DEADBAND    = 8,
  parameter int                    TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  pot_scan_if.master              a2d,
  output logic [NUM_CH*RES_W-1:0] pot_out,
  output logic [NUM_CH-1:0]       pot_vld,
  output logic [NUM_CH-1:0]       chg,
  output logic                    scan_done,
  output logic                    to_err
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW = RES_W + 2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, UPDATE} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_slot;
  logic [TW-1:0]     r_tmo;
  logic [RES_W-1:0]  r_res;
  logic [RES_W-1:0]  r_filt [NUM_CH];
  logic [RES_W-1:0]  r_pot  [NUM_CH];
  logic [NUM_CH-1:0] r_vld;
  logic [NUM_CH-1:0] r_chg;
  logic              r_strt;
  logic              r_done;
  logic              r_toerr;

  logic [RES_W-1:0]     w_filt_cur;
  logic [RES_W-1:0]     w_pot_cur;
  logic signed [FW-1:0] w_diff;
  logic signed [FW-1:0] w_step;
  logic signed [FW-1:0] w_sum;
  logic [RES_W-1:0]     w_filt_new;
  logic signed [FW-1:0] w_delta;
  logic [FW-1:0]        w_mag;
  logic                 w_move;
  logic                 w_last;
  logic [SW-1:0]        w_next_slot;

  assign w_filt_cur = r_filt[r_slot];
  assign w_pot_cur  = r_pot[r_slot];

  // Extra two bits keep the signed difference exact; the shifted step never
  // overshoots the sample, so the sum always fits back into RES_W bits.
  assign w_diff     = $signed({2'b00, r_res}) - $signed({2'b00, w_filt_cur});
  assign w_step     = w_diff >>> ALPHA_SH;
  assign w_sum      = $signed({2'b00, w_filt_cur}) + w_step;
  assign w_filt_new = w_sum[RES_W-1:0];

  assign w_delta = $signed({2'b00, w_filt_new}) - $signed({2'b00, w_pot_cur});
  assign w_mag   = w_delta[FW-1] ? FW'(-w_delta) : FW'(w_delta);
  assign w_move  = (w_mag > FW'(DEADBAND));

  assign w_last      = (r_slot == SW'(NUM_CH - 1));
  assign w_next_slot = w_last ? '0 : r_slot + SW'(1);

  assign a2d.strt_cnv = r_strt;
  assign a2d.chnnl    = CHNL_MAP[3*r_slot +: 3];
  assign pot_vld      = r_vld;
  assign chg          = r_chg;
  assign scan_done    = r_done;
  assign to_err       = r_toerr;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pack
    assign pot_out[gi*RES_W +: RES_W] = r_pot[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_tmo   <= '0;
      r_res   <= '0;
      r_vld   <= '0;
      r_chg   <= '0;
      r_strt  <= 1'b0;
      r_done  <= 1'b0;
      r_toerr <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_filt[i] <= '0;
        r_pot[i]  <= '0;
      end
    end else begin
      r_strt  <= 1'b0;
      r_chg   <= '0;
      r_done  <= 1'b0;
      r_toerr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= START;
            r_strt  <= 1'b1;
          end
        end
        START: begin
          r_state <= WAIT;
          r_tmo   <= '0;
        end
        WAIT: begin
          // A late completion wins over a timeout landing on the same edge.
          if (a2d.cnv_cmplt) begin
            r_res   <= a2d.res;
            r_state <= UPDATE;
          end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
            r_toerr <= 1'b1;
            r_slot  <= w_next_slot;
            r_done  <= w_last;
            r_state <= en ? START : IDLE;
            r_strt  <= en;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        UPDATE: begin
          if (!r_vld[r_slot]) begin
            r_filt[r_slot] <= r_res;
            r_pot[r_slot]  <= r_res;
            r_vld[r_slot]  <= 1'b1;
            r_chg[r_slot]  <= 1'b1;
          end else begin
            r_filt[r_slot] <= w_filt_new;
            if (w_move) begin
              r_pot[r_slot] <= w_filt_new;
              r_chg[r_slot] <= 1'b1;
            end
          end
          r_slot  <= w_next_slot;
          r_done  <= w_last;
          r_state <= en ? START : IDLE;
          r_strt  <= en;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pot_scan.sv
// Directed bench for pot_scan: a small A2D model answers each start pulse after
// a fixed latency from a per-channel result table, with per-channel withholding.
module tb_pot_scan;

  localparam int NUM_CH = 6;
  localparam int RES_W  = 12;
  localparam int TMO    = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en  = 1'b0;
  logic [NUM_CH*RES_W-1:0] pot_out;
  logic [NUM_CH-1:0]       pot_vld;
  logic [NUM_CH-1:0]       chg;
  logic                    scan_done;
  logic                    to_err;

  pot_scan_if #(.RES_W(RES_W)) a2d ();

  pot_scan #(
    .NUM_CH(NUM_CH), .RES_W(RES_W), .ALPHA_SH(2), .DEADBAND(8), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .a2d(a2d.master),
    .pot_out(pot_out), .pot_vld(pot_vld), .chg(chg),
    .scan_done(scan_done), .to_err(to_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [RES_W-1:0] resTable [8];
  bit               withhold [8];
  int               mdlCnt = 0;
  logic [2:0]       mdlCh  = 3'd0;

  // A2D model: completion arrives two falling edges after the start pulse is seen.
  always @(negedge clk) begin
    a2d.cnv_cmplt = 1'b0;
    if (mdlCnt > 0) begin
      mdlCnt = mdlCnt - 1;
      if (mdlCnt == 0) begin
        a2d.res       = resTable[mdlCh];
        a2d.cnv_cmplt = !withhold[mdlCh];
      end
    end
    if (a2d.strt_cnv) begin
      mdlCnt = 2;
      mdlCh  = a2d.chnnl;
    end
  end

  int         scanCnt  = 0;
  int         toErrCnt = 0;
  int         chgCnt [NUM_CH];
  logic [2:0] strtLog [$];

  always @(posedge clk) begin
    #1;
    if (scan_done) scanCnt++;
    if (to_err) toErrCnt++;
    for (int i = 0; i < NUM_CH; i++) chgCnt[i] += int'(chg[i]);
    if (a2d.strt_cnv) strtLog.push_back(a2d.chnnl);
  end

  function automatic logic [RES_W-1:0] potOf(input int i);
    return pot_out[i*RES_W +: RES_W];
  endfunction

  function automatic logic [3:0] logAt(input int i);
    if (i < strtLog.size()) return {1'b0, strtLog[i]};
    return 4'hF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input int cycles);
    rst = r;
    en  = e;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitScan();
    int s = scanCnt;
    int n = 0;
    while (scanCnt == s && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scan_wait", 32'(scanCnt != s), 32'd1);
  endtask

  task automatic waitStrt(input int chn, input string tag);
    int n = 0;
    while (!(a2d.strt_cnv && (chn < 0 || a2d.chnnl == 3'(chn))) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(a2d.strt_cnv), 32'd1);
  endtask

  initial begin
    logic [2:0]       expSeq [7];
    logic [RES_W-1:0] expStep [3];
    int base;
    int snapChg;
    int n;

    expSeq  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0};
    expStep = '{12'h900, 12'h9C0, 12'hA50};
    for (int i = 0; i < 8; i++) begin
      resTable[i] = 12'h800;
      withhold[i] = 1'b0;
    end

    // Reset state
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("rst_strt", 32'(a2d.strt_cnv), 32'd0);
    checkOutput("rst_chnnl", 32'(a2d.chnnl), 32'd0);
    checkOutput("rst_pot_out", 32'(|pot_out), 32'd0);
    checkOutput("rst_pot_vld", 32'(pot_vld), 32'd0);
    checkOutput("rst_chg", 32'(chg), 32'd0);
    checkOutput("rst_scan_done", 32'(scan_done), 32'd0);
    checkOutput("rst_to_err", 32'(to_err), 32'd0);

    // First scan at a flat 0x800
    applyStimulus(1'b0, 1'b1, 0);
    waitScan();
    for (int i = 0; i < 7; i++) checkOutput($sformatf("seq_chnnl%0d", i), 32'(logAt(i)), 32'(expSeq[i]));
    checkOutput("seq_len", 32'(strtLog.size()), 32'd7);
    for (int i = 0; i < NUM_CH; i++) begin
      checkOutput($sformatf("first_pot%0d", i), 32'(potOf(i)), 32'h800);
      checkOutput($sformatf("first_chg%0d", i), 32'(chgCnt[i]), 32'd1);
    end
    checkOutput("first_vld", 32'(pot_vld), 32'h3F);
    checkOutput("first_scans", 32'(scanCnt), 32'd1);

    // Slot 5 steps to 0xC00 and converges through the IIR
    resTable[7] = 12'hC00;
    for (int j = 0; j < 3; j++) begin
      waitScan();
      checkOutput($sformatf("step_pot5_%0d", j), 32'(potOf(5)), 32'(expStep[j]));
      checkOutput($sformatf("step_chg5_%0d", j), 32'(chgCnt[5]), 32'(2 + j));
    end
    for (int i = 0; i < 5; i++) checkOutput($sformatf("step_quiet%0d", i), 32'(chgCnt[i]), 32'd1);

    // Reset during WAIT followed by a stray completion
    waitStrt(2, "rstwait_strt");
    snapChg = chgCnt[0] + chgCnt[1] + chgCnt[2] + chgCnt[3] + chgCnt[4] + chgCnt[5];
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    base = strtLog.size();
    repeat (5) @(negedge clk);
    checkOutput("stray_pot_out", 32'(|pot_out), 32'd0);
    checkOutput("stray_vld", 32'(pot_vld), 32'd0);
    checkOutput("stray_chg", 32'(chgCnt[0] + chgCnt[1] + chgCnt[2] + chgCnt[3] + chgCnt[4] + chgCnt[5]), 32'(snapChg));
    checkOutput("stray_strt", 32'(strtLog.size()), 32'(base));
    checkOutput("stray_chnnl", 32'(a2d.chnnl), 32'd0);
    checkOutput("stray_done", 32'(scan_done), 32'd0);

    // Restart at slot 0 with slot 2 dithering around 0x400
    for (int i = 0; i < 8; i++) resTable[i] = 12'h800;
    resTable[2] = 12'h400;
    snapChg = chgCnt[2];
    en = 1'b1;
    waitScan();
    checkOutput("restart_chnnl", 32'(logAt(base)), 32'd0);
    checkOutput("dither_first", 32'(potOf(2)), 32'h400);
    checkOutput("dither_first_chg", 32'(chgCnt[2]), 32'(snapChg + 1));
    checkOutput("restart_vld", 32'(pot_vld), 32'h3F);
    snapChg = chgCnt[2];
    for (int k = 0; k < 4; k++) begin
      resTable[2] = (k % 2 == 0) ? 12'h404 : 12'h400;
      waitScan();
      checkOutput($sformatf("dither_pot_%0d", k), 32'(potOf(2)), 32'h400);
    end
    checkOutput("dither_chg", 32'(chgCnt[2]), 32'(snapChg));

    // Slot 3 never completes
    withhold[3] = 1'b1;
    snapChg = chgCnt[3];
    base = toErrCnt;
    waitStrt(3, "tmo_strt");
    @(negedge clk);
    n = 0;
    while (!to_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    withhold[3] = 1'b0;
    checkOutput("tmo_delay", 32'(n), 32'(TMO));
    checkOutput("tmo_next_chnnl", 32'(logAt(strtLog.size() - 1)), 32'd4);
    waitScan();
    checkOutput("tmo_count", 32'(toErrCnt - base), 32'd1);
    checkOutput("tmo_pot3", 32'(potOf(3)), 32'h800);
    checkOutput("tmo_chg3", 32'(chgCnt[3]), 32'(snapChg));

    // Drop en while slot 1 is converting
    resTable[1] = 12'h900;
    snapChg = chgCnt[1];
    waitStrt(1, "en_strt");
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("en_pot1", 32'(potOf(1)), 32'h840);
    checkOutput("en_chg1", 32'(chgCnt[1]), 32'(snapChg + 1));
    checkOutput("en_idle_chnnl", 32'(a2d.chnnl), 32'd2);
    checkOutput("en_idle_last", 32'(logAt(strtLog.size() - 1)), 32'd1);
    checkOutput("en_idle_strt", 32'(a2d.strt_cnv), 32'd0);
    en = 1'b1;
    waitStrt(-1, "resume_strt");
    checkOutput("resume_chnnl", 32'(a2d.chnnl), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
